// File: rtl/fir_pkg.sv
// Shared types and constant helpers for the sample-path FIR filters.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    function automatic int clog2(input int n);
        int r = 32'sd0;
        while ((32'sd1 <<< r) < n) r = r + 32'sd1;
        return r;
    endfunction

    // Largest / smallest value representable in a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_hi(input int w);
        return (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lo(input int w);
        return -(64'sd1 <<< (w - 32'sd1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up arithmetic right shift of an accumulator, clamped to a signed
// OUT_W range. Purely combinational so any filter can drop it in front of its output register.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15,
    parameter int OUT_W     = 32
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y
);

    // One guard bit keeps the rounding offset from wrapping a near-full-scale sum.
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] ONE    = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] HALF   = ONE <<< (OUT_SHIFT - 1);
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(OUT_W));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(OUT_W));

    logic signed [SW-1:0] biased_s;
    logic signed [SW-1:0] shifted_s;

    assign biased_s  = {acc[ACC_W-1], acc} + HALF;
    assign shifted_s = biased_s >>> OUT_SHIFT;

    // Clamp the scaled value into the output range.
    always_comb begin
        y = '0;
        if (shifted_s > SAT_HI) begin
            y = SAT_HI[OUT_W-1:0];
        end else if (shifted_s < SAT_LO) begin
            y = SAT_LO[OUT_W-1:0];
        end else begin
            y = shifted_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: a single signed MAC walks all taps per sample, with a
// circular history buffer, run-time coefficients and valid/ready streaming.
module fir_mac_serial
    import fir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 64,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       coef_we,
    input  logic [clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       busy
);

    localparam int AW = clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    localparam logic [AW-1:0] ONE_A  = AW'(32'd1);
    localparam logic [AW:0]   TAPS_X = (AW + 1)'(TAPS);

    fir_state_e state_r, state_s;
    logic [AW-1:0]             wp_r, k_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic signed [DATA_W-1:0]  hist_r [TAPS];
    logic signed [COEF_W-1:0]  coef_r [TAPS];

    logic [AW:0]               rd_wide_s;
    logic [AW-1:0]             rd_idx_s;
    logic signed [PW-1:0]      x_ext_s, h_ext_s, prod_s;
    logic signed [ACC_W-1:0]   acc_sum_s;
    logic signed [OUT_W-1:0]   rs_y_s;

    // History index for tap k: newest sample sits at wp, older ones behind it.
    always_comb begin
        rd_wide_s = '0;
        if (wp_r >= k_r) begin
            rd_wide_s = {1'b0, wp_r} - {1'b0, k_r};
        end else begin
            rd_wide_s = {1'b0, wp_r} + TAPS_X - {1'b0, k_r};
        end
        rd_idx_s = rd_wide_s[AW-1:0];
    end

    assign x_ext_s   = {{COEF_W{hist_r[rd_idx_s][DATA_W-1]}}, hist_r[rd_idx_s]};
    assign h_ext_s   = {{DATA_W{coef_r[k_r][COEF_W-1]}}, coef_r[k_r]};
    assign prod_s    = x_ext_s * h_ext_s;
    assign acc_sum_s = acc_r + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};

    fir_round_sat #(
        .ACC_W     (ACC_W),
        .OUT_SHIFT (OUT_SHIFT),
        .OUT_W     (OUT_W)
    ) u_round_sat (
        .acc (acc_sum_s),
        .y   (rs_y_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid) state_s = MAC;  else state_s = IDLE;
            MAC:     if (k_r == LAST) state_s = OUT; else state_s = MAC;
            OUT:     if (out_ready) state_s = IDLE; else state_s = OUT;
            default: state_s = IDLE;
        endcase
    end

    // State register and the handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_s;
            in_ready  <= (state_s == IDLE);
            busy      <= (state_s != IDLE);
            out_valid <= (state_s == OUT);
        end
    end

    // Tap counter, accumulator, write pointer and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_r     <= '0;
            k_r      <= '0;
            acc_r    <= '0;
            out_data <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        acc_r <= '0;
                        k_r   <= '0;
                    end
                end
                MAC: begin
                    acc_r <= acc_sum_s;
                    if (k_r == LAST) begin
                        out_data <= rs_y_s;
                        wp_r     <= (wp_r == LAST) ? '0 : wp_r + ONE_A;
                    end else begin
                        k_r <= k_r + ONE_A;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sample history: accepted samples land at the write pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) hist_r[i] <= '0;
        end else if (state_r == IDLE && in_valid) begin
            hist_r[wp_r] <= in_data;
        end
    end

    // Coefficients change only while idle so a running sum never mixes old and new taps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) coef_r[i] <= '0;
        end else if (coef_we && state_r == IDLE && ({1'b0, coef_addr} < TAPS_X)) begin
            coef_r[coef_addr] <= coef_wdata;
        end
    end

endmodule
